// File: rtl/turn_scheduler.sv
// Two-player turn scheduler for a 4x4 board: arbitrates move requests, issues
// board write/clear commands and enforces a per-turn frame timeout.
module turn_scheduler #(
    parameter int unsigned TIMEOUT_FRAMES = 600,
    parameter int unsigned FIRST_PLAYER   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        frame_tick,
    input  logic        p1_req,
    input  logic        p2_req,
    input  logic [3:0]  p1_cell,
    input  logic [3:0]  p2_cell,
    input  logic [15:0] board_occ,
    output logic        wr_en,
    output logic [3:0]  wr_cell,
    output logic [1:0]  wr_who,
    output logic        board_clr,
    output logic        p1_ack,
    output logic        p1_nak,
    output logic        p2_ack,
    output logic        p2_nak,
    output logic [1:0]  who,
    output logic        timeout
);

    typedef enum logic [2:0] {StIdle, StP1Turn, StP2Turn, StCommit, StFull} state_e;

    localparam state_e     FirstTurn   = (FIRST_PLAYER == 2) ? StP2Turn : StP1Turn;
    localparam logic [9:0] TimeoutLast = 10'(TIMEOUT_FRAMES - 1);

    state_e      state_q, state_d;
    logic [9:0]  timer_q, timer_d;
    logic [3:0]  cell_q, cell_d;
    logic [1:0]  owner_q, owner_d;
    logic        p1_ack_q, p1_ack_d, p1_nak_q, p1_nak_d;
    logic        p2_ack_q, p2_ack_d, p2_nak_q, p2_nak_d;
    logic        clr_q, clr_d, timeout_q, timeout_d;

    logic        is_p1;
    logic        act_req, oth_req, act_ack, act_nak;
    logic [3:0]  act_cell;
    logic [15:0] cell_bit;

    assign cell_bit = 16'd1 << cell_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        cell_d    = cell_q;
        owner_d   = owner_q;
        p1_ack_d  = 1'b0;
        p1_nak_d  = 1'b0;
        p2_ack_d  = 1'b0;
        p2_nak_d  = 1'b0;
        clr_d     = 1'b0;
        timeout_d = 1'b0;
        is_p1     = (state_q == StP1Turn);
        act_req   = is_p1 ? p1_req : p2_req;
        oth_req   = is_p1 ? p2_req : p1_req;
        act_cell  = is_p1 ? p1_cell : p2_cell;
        act_ack   = 1'b0;
        act_nak   = 1'b0;

        if (abort) begin
            // Abort overrides everything; any request this cycle goes unserved.
            state_d  = StIdle;
            timer_d  = '0;
            p1_nak_d = p1_req;
            p2_nak_d = p2_req;
        end else begin
            unique case (state_q)
                StIdle, StFull: begin
                    p1_nak_d = p1_req;
                    p2_nak_d = p2_req;
                    if (start) begin
                        state_d = FirstTurn;
                        timer_d = '0;
                        clr_d   = 1'b1;
                    end
                end
                StP1Turn, StP2Turn: begin
                    if (act_req && !board_occ[act_cell]) begin
                        act_ack = 1'b1;
                        cell_d  = act_cell;
                        owner_d = is_p1 ? 2'b01 : 2'b10;
                        state_d = StCommit;
                    end else begin
                        act_nak = act_req;
                        if (frame_tick) begin
                            if (timer_q == TimeoutLast) begin
                                timeout_d = 1'b1;
                                timer_d   = '0;
                                state_d   = is_p1 ? StP2Turn : StP1Turn;
                            end else begin
                                timer_d = timer_q + 10'd1;
                            end
                        end
                    end
                    if (is_p1) begin
                        p1_ack_d = act_ack;
                        p1_nak_d = act_nak;
                        p2_nak_d = oth_req;
                    end else begin
                        p2_ack_d = act_ack;
                        p2_nak_d = act_nak;
                        p1_nak_d = oth_req;
                    end
                end
                StCommit: begin
                    p1_nak_d = p1_req;
                    p2_nak_d = p2_req;
                    timer_d  = '0;
                    // board_occ does not yet include this write, so fold it in.
                    if ((board_occ | cell_bit) == 16'hFFFF) begin
                        state_d = StFull;
                    end else begin
                        state_d = (owner_q == 2'b01) ? StP2Turn : StP1Turn;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            cell_q    <= '0;
            owner_q   <= '0;
            p1_ack_q  <= 1'b0;
            p1_nak_q  <= 1'b0;
            p2_ack_q  <= 1'b0;
            p2_nak_q  <= 1'b0;
            clr_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cell_q    <= cell_d;
            owner_q   <= owner_d;
            p1_ack_q  <= p1_ack_d;
            p1_nak_q  <= p1_nak_d;
            p2_ack_q  <= p2_ack_d;
            p2_nak_q  <= p2_nak_d;
            clr_q     <= clr_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        who = 2'b00;
        unique case (state_q)
            StIdle:   who = 2'b00;
            StP1Turn: who = 2'b01;
            StP2Turn: who = 2'b10;
            StCommit: who = owner_q;
            StFull:   who = 2'b11;
            default:  who = 2'b00;
        endcase
    end

    // A same-cycle abort cancels the commit write.
    assign wr_en     = (state_q == StCommit) && !abort;
    assign wr_cell   = wr_en ? cell_q : 4'd0;
    assign wr_who    = wr_en ? owner_q : 2'b00;
    assign board_clr = clr_q;
    assign p1_ack    = p1_ack_q;
    assign p1_nak    = p1_nak_q;
    assign p2_ack    = p2_ack_q;
    assign p2_nak    = p2_nak_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: directed vector table, reset-in-commit sequence,
// then randomized traffic against a game-level reference model.
module tb_turn_scheduler;

    localparam int TO    = 3;
    localparam int FIRST = 1;

    logic        clk, reset, start, abort, frame_tick, p1_req, p2_req;
    logic [3:0]  p1_cell, p2_cell;
    logic [15:0] board_occ;
    logic        wr_en, board_clr, p1_ack, p1_nak, p2_ack, p2_nak, timeout;
    logic [3:0]  wr_cell;
    logic [1:0]  wr_who, who;

    turn_scheduler #(.TIMEOUT_FRAMES(TO), .FIRST_PLAYER(FIRST)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .frame_tick(frame_tick),
        .p1_req(p1_req), .p2_req(p2_req), .p1_cell(p1_cell), .p2_cell(p2_cell),
        .board_occ(board_occ), .wr_en(wr_en), .wr_cell(wr_cell), .wr_who(wr_who),
        .board_clr(board_clr), .p1_ack(p1_ack), .p1_nak(p1_nak), .p2_ack(p2_ack),
        .p2_nak(p2_nak), .who(who), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    typedef struct {
        int st, ab, tk, r1, c1, r2, c2, occ;
        int who, wen, wc, ww, a1, n1, a2, n2, clr, tmo;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(int st, int ab, int tk, int r1, int c1, int r2, int c2, int occ,
                                int w, int wen, int wc, int ww, int a1, int n1, int a2, int n2,
                                int clr, int tmo);
        vec_t v;
        v = '{st, ab, tk, r1, c1, r2, c2, occ, w, wen, wc, ww, a1, n1, a2, n2, clr, tmo};
        tbl.push_back(v);
    endfunction

    // Reference model: game phase 0 idle, 1 turn, 2 committing, 3 full.
    int m_ph, m_turn, m_ticks, m_cell;
    bit e_p1a, e_p1n, e_p2a, e_p2n, e_clr, e_tmo;

    task automatic m_reset();
        m_ph = 0; m_turn = 0; m_ticks = 0; m_cell = 0;
        {e_p1a, e_p1n, e_p2a, e_p2n, e_clr, e_tmo} = '0;
    endtask

    task automatic m_step();
        bit r1, r2, mreq, oreq, mack, mnak;
        int mc, mv;
        r1 = p1_req; r2 = p2_req;
        {e_p1a, e_p1n, e_p2a, e_p2n, e_clr, e_tmo} = '0;
        if (abort) begin
            m_ph = 0; e_p1n = r1; e_p2n = r2;
        end else if (m_ph == 0 || m_ph == 3) begin
            e_p1n = r1; e_p2n = r2;
            if (start) begin m_ph = 1; m_turn = FIRST; m_ticks = 0; e_clr = 1; end
        end else if (m_ph == 2) begin
            e_p1n = r1; e_p2n = r2;
            if ((board_occ | (16'd1 << m_cell)) == 16'hFFFF) m_ph = 3;
            else begin m_ph = 1; m_turn = 3 - m_turn; m_ticks = 0; end
        end else begin
            mv   = m_turn;
            mreq = (mv == 1) ? r1 : r2;
            oreq = (mv == 1) ? r2 : r1;
            mc   = (mv == 1) ? int'(p1_cell) : int'(p2_cell);
            mack = 0; mnak = 0;
            if (mreq && !board_occ[mc]) begin
                mack = 1; m_cell = mc; m_ph = 2;
            end else begin
                mnak = mreq;
                if (frame_tick) begin
                    m_ticks++;
                    if (m_ticks == TO) begin e_tmo = 1; m_turn = 3 - m_turn; m_ticks = 0; end
                end
            end
            if (mv == 1) begin e_p1a = mack; e_p1n = mnak; e_p2n = oreq; end
            else begin e_p2a = mack; e_p2n = mnak; e_p1n = oreq; end
        end
    endtask

    task automatic chk_model(input string tag);
        int ew, een;
        ew  = (m_ph == 0) ? 0 : (m_ph == 3) ? 3 : m_turn;
        een = (m_ph == 2 && !abort) ? 1 : 0;
        chk({tag, " who"}, who, ew);
        chk({tag, " wr_en"}, wr_en, een);
        if (een == 1) begin
            chk({tag, " wr_cell"}, wr_cell, m_cell);
            chk({tag, " wr_who"}, wr_who, m_turn);
        end
        chk({tag, " p1_ack"}, p1_ack, e_p1a);
        chk({tag, " p1_nak"}, p1_nak, e_p1n);
        chk({tag, " p2_ack"}, p2_ack, e_p2a);
        chk({tag, " p2_nak"}, p2_nak, e_p2n);
        chk({tag, " board_clr"}, board_clr, e_clr);
        chk({tag, " timeout"}, timeout, e_tmo);
    endtask

    task automatic drive(int st, int ab, int tk, int r1, int c1, int r2, int c2, int occ);
        start = st[0]; abort = ab[0]; frame_tick = tk[0];
        p1_req = r1[0]; p1_cell = 4'(c1); p2_req = r2[0]; p2_cell = 4'(c2);
        board_occ = 16'(occ);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        string t;
        t = $sformatf("row%0d", i);
        drive(v.st, v.ab, v.tk, v.r1, v.c1, v.r2, v.c2, v.occ);
        @(negedge clk);
        chk({t, " who"}, who, v.who);
        chk({t, " wr_en"}, wr_en, v.wen);
        if (v.wen == 1) begin
            chk({t, " wr_cell"}, wr_cell, v.wc);
            chk({t, " wr_who"}, wr_who, v.ww);
        end
        chk({t, " p1_ack"}, p1_ack, v.a1);
        chk({t, " p1_nak"}, p1_nak, v.n1);
        chk({t, " p2_ack"}, p2_ack, v.a2);
        chk({t, " p2_nak"}, p2_nak, v.n2);
        chk({t, " board_clr"}, board_clr, v.clr);
        chk({t, " timeout"}, timeout, v.tmo);
        @(posedge clk);
        m_step();
        #1;
    endtask

    logic [15:0] board;

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_model("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        //  st ab tk r1 c1 r2 c2 occ       who wen wc ww a1 n1 a2 n2 clr tmo
        add(0, 0, 0, 0, 0, 0, 0, 'h0000,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 'h0000,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0000,   1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0000,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 5, 0, 0, 'h0000,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0000,   1, 1, 5, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0020,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 3, 1, 5, 'h0020,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0020,   2, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0020,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 7, 'h0020,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0020,   0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 'h0000,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0000,   1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 'h0000,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 'h0000,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 'h0000,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0000,   2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 'h0020,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 'h0020,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 'h0020,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 9, 'h0020,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0020,   2, 1, 9, 2, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0220,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 'hFFFE,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'hFFFE,   1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'hFFFF,   3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 2, 0, 0, 'hFFFF,   3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 'hFFFF,   3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0000,   1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 'h0000,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0000,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 4, 'h0000,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'h0000,   1, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        foreach (tbl[i]) run_vec(i, tbl[i]);

        // Reset asserted mid-COMMIT must kill the write at once.
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("commit wr_en before reset", wr_en, 1);
        reset = 1'b0;
        #1;
        chk("reset-in-commit wr_en", wr_en, 0);
        chk("reset-in-commit who", who, 0);
        chk("reset-in-commit p1_ack", p1_ack, 0);
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_model($sformatf("post-reset%0d", i));
            @(posedge clk);
            m_step();
            #1;
        end

        board = '0;
        for (int i = 0; i < 4000; i++) begin
            logic [15:0] nb;
            drive(($urandom_range(0, 99) < 5) ? 1 : 0, ($urandom_range(0, 199) < 2) ? 1 : 0,
                  ($urandom_range(0, 99) < 30) ? 1 : 0,
                  ($urandom_range(0, 99) < 30) ? 1 : 0, int'($urandom_range(0, 15)),
                  ($urandom_range(0, 99) < 30) ? 1 : 0, int'($urandom_range(0, 15)),
                  int'(board));
            @(negedge clk);
            chk_model($sformatf("rand%0d", i));
            nb = board;
            if (board_clr) nb = '0;
            else if (wr_en) nb = nb | (16'd1 << wr_cell);
            @(posedge clk);
            m_step();
            board = nb;
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/turn_scheduler.md
TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 Parameter TIMEOUT_FRAMES, default 600, SHALL set the frame_tick count after which the active player forfeits the turn (range 2..1023).
REQ-002 Parameter FIRST_PLAYER, default 1, SHALL select the player owning the first turn (1 = player 1, 2 = player 2).
REQ-003 clk  input  1  SHALL be the single clock for the block (25 MHz pixel clock domain).
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle pulse that starts a new game.
REQ-006 abort  input  1  SHALL be a one-cycle synchronous abort request.
REQ-007 frame_tick  input  1  SHALL be a one-cycle pulse per video frame, used as the turn-timer timebase.
REQ-008 p1_req, p2_req  input  1 each  SHALL be per-player move-request pulses.
REQ-009 p1_cell, p2_cell  input  4 each  SHALL give the requested cell index 0..15, valid with the matching req.
REQ-010 board_occ  input  16  SHALL report cell occupancy from the board register, bit i = cell i.
REQ-011 wr_en  output  1, wr_cell  output  4, wr_who  output  2  SHALL form the board write command.
REQ-012 board_clr  output  1  SHALL be a one-cycle clear command to the board register.
REQ-013 p1_ack, p1_nak, p2_ack, p2_nak  output  1 each  SHALL be per-player request responses.
REQ-014 who  output  2  SHALL encode phase: 00 idle, 01 player-1 turn, 10 player-2 turn, 11 board full.
REQ-015 timeout  output  1  SHALL pulse for one cycle when a turn is forfeited.

Function
REQ-016 FSM states SHALL be IDLE, P1_TURN, P2_TURN, COMMIT, FULL; who = 00/01/10 per state, holds the previous turn's value during COMMIT, and is 11 in FULL.
REQ-017 IDLE + start SHALL go to the FIRST_PLAYER turn state and assert board_clr for exactly the next cycle.
REQ-018 In a turn state, a valid active request (req=1 and board_occ[cell]=0) SHALL latch cell and owner, go to COMMIT, and assert ack for one cycle.
REQ-019 An active request to an occupied cell SHALL assert nak for one cycle and leave the state unchanged.
REQ-020 Any request from the inactive player, or any request in IDLE, COMMIT or FULL, SHALL assert that player's nak for one cycle with no other effect.
REQ-021 If both players request in the same cycle, the active player's request SHALL be served per REQ-018/019 and the other SHALL receive nak.
REQ-022 COMMIT SHALL last exactly one cycle, with wr_en=1, wr_cell = latched cell, wr_who = 01 or 10; wr_en SHALL be 0 in every other state.
REQ-023 Latency: request sampled at edge N SHALL give ack and wr_en both high in cycle N+1, and the opponent's turn state (or FULL) at edge N+1.
REQ-024 Exit from COMMIT SHALL go to FULL if (board_occ | onehot(wr_cell)) == 16'hFFFF, otherwise to the opponent's turn state.
REQ-025 The turn timer (10 bits) SHALL clear on every entry to a turn state and increment on frame_tick while in a turn state; frame_tick in other states SHALL be ignored.
REQ-026 When the timer reaches TIMEOUT_FRAMES, the block SHALL pulse timeout, switch to the opponent's turn state, and write nothing.
REQ-027 A valid request in the same cycle as the timeout-causing frame_tick SHALL take priority; the move commits and timeout stays 0.
REQ-028 FULL SHALL hold until start, which behaves as in REQ-017.
REQ-029 A start pulse in a turn state or COMMIT SHALL be ignored.
REQ-030 abort in any state SHALL return to IDLE on the next edge with no write; abort SHALL take priority over start, requests and timeout in the same cycle.
REQ-031 Every ack, nak, timeout and board_clr pulse SHALL be registered and last exactly one cycle.

Reset
REQ-032 While reset=0, the FSM SHALL be in IDLE, the timer and latched cell SHALL be 0, and all outputs SHALL be 0 (who=00), asynchronously.
REQ-033 Reset asserted during COMMIT SHALL suppress the pending write immediately; after release the block SHALL wait in IDLE for start.

Verification
REQ-034 Release reset, pulse start (FIRST_PLAYER=1) -> board_clr high for 1 cycle; who=01.
REQ-035 In P1_TURN, p1_req with p1_cell=5 and board_occ=0 -> next cycle p1_ack=1, wr_en=1, wr_cell=5, wr_who=01; then who=10.
REQ-036 In P2_TURN, p1_req and p2_req together, p2_cell=5 with board_occ[5]=1 -> p2_nak=1 and p1_nak=1, no write, who stays 10.
REQ-037 TIMEOUT_FRAMES=3, no requests, 3 frame_ticks in P1_TURN -> timeout pulse, who=10, wr_en never high.
REQ-038 board_occ=16'hFFFE in P1_TURN, p1_req with p1_cell=0 -> write to cell 0 for one cycle, then who=11; a later start -> board_clr and who=01.
REQ-039 In P2_TURN, abort together with a valid p2_req -> no ack, no write, who=00 next cycle.
